reaction_round_ctrl: RTL and testbench
======================================

REACTION_ROUND_CTRL -- requirements
Module: reaction_round_ctrl

Interface
REQ-001 Parameter: NUM_ROUNDS, default 5, rounds per session (1..7).
REQ-002 Parameter: MAX_MS, default 9999, reaction-time saturation value in ms.
REQ-003 Parameter: PENALTY_MS, default 1000, false-start lockout in ms.
REQ-004 clk  in  1  system clock; single clock domain; all logic on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 tick  in  1  1 ms enable strobe, one clk cycle wide, synchronous to clk.
REQ-007 start_btn  in  1  session start button, level, pre-synchronised.
REQ-008 react_btn  in  1  player reaction button, level, pre-synchronised.
REQ-009 lights_out  in  1  one-cycle pulse from lights sequencer when all lights extinguish.
REQ-010 trigger  out  1  one-cycle pulse that starts the lights sequencer.
REQ-011 seq_abort  out  1  one-cycle pulse that returns the lights sequencer to its wait state.
REQ-012 rt_ms  out  14  last recorded reaction time, ms.
REQ-013 best_ms  out  14  best reaction time this session, ms.
REQ-014 round_idx  out  3  completed-round count, 0..NUM_ROUNDS.
REQ-015 false_start  out  1  high while in PENALTY.
REQ-016 done  out  1  high while in DONE.
REQ-017 state_dbg  out  3  current state encoding.

Function
REQ-018 Inputs start_btn and react_btn SHALL be rising-edge detected (registered previous value); only edges act, held levels do nothing.
REQ-019 States: IDLE, ARM, LIGHTS, MEASURE, RECORD, PENALTY, DONE.
REQ-020 IDLE: on start edge -> ARM; clear round_idx to 0, rt_ms to 0, best_ms to MAX_MS.
REQ-021 ARM: trigger SHALL be high for exactly this one cycle; next state LIGHTS.
REQ-022 LIGHTS: react edge -> PENALTY with seq_abort pulsed in the same cycle as the transition; lights_out -> MEASURE with ms counter cleared to 0.
REQ-023 LIGHTS with react edge and lights_out in the same cycle SHALL be treated as false start.
REQ-024 MEASURE: ms counter increments by 1 on each tick; react edge -> RECORD latching counter value; counter reaching MAX_MS -> RECORD with MAX_MS (timeout).
REQ-025 MEASURE with tick and react edge in the same cycle: the latched value SHALL exclude that tick.
REQ-026 Counter SHALL never exceed MAX_MS (saturating, no wrap).
REQ-027 RECORD (one cycle): rt_ms <= latched value; best_ms <= min(best_ms, latched); round_idx increments; if new round_idx == NUM_ROUNDS -> DONE else ARM.
REQ-028 PENALTY: counts PENALTY_MS ticks, then -> ARM; round_idx, rt_ms, best_ms unchanged; react edges ignored.
REQ-029 DONE: outputs hold; start edge -> IDLE-equivalent clear then ARM (new session) in the next cycle.
REQ-030 start edges SHALL be ignored in all states except IDLE and DONE.
REQ-031 lights_out outside LIGHTS SHALL be ignored.

Reset
REQ-032 rst_n low at a clk edge SHALL force state IDLE, counters 0, rt_ms 0, best_ms MAX_MS, round_idx 0, all pulse/flag outputs 0, edge registers 0, overriding any in-progress round.
REQ-033 A button held through reset release SHALL NOT produce an edge.

Structure
REQ-034 Shared package holds state encoding, 14-bit time width, and default MAX_MS/PENALTY_MS constants.
REQ-035 One sub-module edge_det (registered rising-edge detector) SHALL be instantiated for each button.

Verification
REQ-036 Normal round: start, lights_out, react edge after 250 ticks -> rt_ms=250, best_ms=250, round_idx=1, trigger pulsed once per ARM.
REQ-037 Full session: 5 rounds of 300,180,220,400,190 ticks -> best_ms=180, rt_ms=190, done=1, round_idx=5.
REQ-038 False start: react edge in LIGHTS -> seq_abort 1 cycle, false_start high 1000 ticks, then trigger re-pulses, round_idx unchanged.
REQ-039 Timeout: no react for 9999 ticks after lights_out -> rt_ms=9999, round advances.
REQ-040 Simultaneous react and lights_out -> PENALTY; react and tick same cycle at count 120 -> rt_ms=120.
REQ-041 rst_n low mid-MEASURE -> next cycle state IDLE, best_ms=9999, all outputs at reset values.

Source files
------------

// File: rtl/reaction_round_ctrl_pkg.sv
// Shared definitions for the reaction-round controller: time width, default
// timing constants and the state encoding exposed on state_dbg.
package reaction_round_ctrl_pkg;

    localparam int TIME_W             = 14;
    localparam int DEFAULT_MAX_MS     = 9999;
    localparam int DEFAULT_PENALTY_MS = 1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_LIGHTS  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_RECORD  = 3'd4,
        ST_PENALTY = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/reaction_round_ctrl_edge_det.sv
// Registered rising-edge detector for a pre-synchronised button level.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;
    logic r_armed;

    // r_armed stays low for the first cycle after reset so a button held
    // through reset release is absorbed into r_prev instead of firing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_sig;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_sig & ~r_prev & r_armed;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round/session controller for a lights-out reaction game: arms the lights
// sequencer, times the player in ms, tracks best time and handles false starts.
module reaction_round_ctrl
    import reaction_round_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = 5,
    parameter int MAX_MS     = DEFAULT_MAX_MS,
    parameter int PENALTY_MS = DEFAULT_PENALTY_MS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              start_btn,
    input  logic              react_btn,
    input  logic              lights_out,
    output logic              trigger,
    output logic              seq_abort,
    output logic [TIME_W-1:0] rt_ms,
    output logic [TIME_W-1:0] best_ms,
    output logic [2:0]        round_idx,
    output logic              false_start,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam logic [TIME_W-1:0] LP_MAX    = TIME_W'(MAX_MS);
    localparam logic [TIME_W-1:0] LP_PEN    = TIME_W'(PENALTY_MS);
    localparam logic [2:0]        LP_ROUNDS = 3'(NUM_ROUNDS);

    state_t            r_state;
    logic [TIME_W-1:0] r_cnt;
    logic [TIME_W-1:0] r_latch;
    logic [TIME_W-1:0] r_rt;
    logic [TIME_W-1:0] r_best;
    logic [2:0]        r_round;
    logic              r_trigger;
    logic              r_abort;

    logic              w_start_edge;
    logic              w_react_edge;
    logic [TIME_W-1:0] w_cnt_inc;
    logic [2:0]        w_round_inc;

    edge_det u_start_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (start_btn),
        .o_rise (w_start_edge)
    );

    edge_det u_react_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (react_btn),
        .o_rise (w_react_edge)
    );

    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_round_inc = r_round + 3'd1;

    // One counter serves both reaction timing and penalty lockout; a react
    // edge wins over lights_out and over a same-cycle tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_latch   <= '0;
            r_rt      <= '0;
            r_best    <= LP_MAX;
            r_round   <= '0;
            r_trigger <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_trigger <= 1'b0;
            r_abort   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_edge) begin
                        r_round   <= '0;
                        r_rt      <= '0;
                        r_best    <= LP_MAX;
                        r_trigger <= 1'b1;
                        r_state   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_state <= ST_LIGHTS;
                end
                ST_LIGHTS: begin
                    if (w_react_edge) begin
                        r_abort <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_PENALTY;
                    end else if (lights_out) begin
                        r_cnt   <= '0;
                        r_state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_react_edge) begin
                        r_latch <= r_cnt;
                        r_state <= ST_RECORD;
                    end else if (r_cnt >= LP_MAX) begin
                        r_latch <= LP_MAX;
                        r_state <= ST_RECORD;
                    end else if (tick) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == LP_MAX) begin
                            r_latch <= LP_MAX;
                            r_state <= ST_RECORD;
                        end
                    end
                end
                ST_RECORD: begin
                    r_rt    <= r_latch;
                    r_round <= w_round_inc;
                    if (r_latch < r_best) begin
                        r_best <= r_latch;
                    end
                    if (w_round_inc == LP_ROUNDS) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_trigger <= 1'b1;
                        r_state   <= ST_ARM;
                    end
                end
                ST_PENALTY: begin
                    if (tick) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= LP_PEN) begin
                            r_trigger <= 1'b1;
                            r_state   <= ST_ARM;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign trigger     = r_trigger;
    assign seq_abort   = r_abort;
    assign rt_ms       = r_rt;
    assign best_ms     = r_best;
    assign round_idx   = r_round;
    assign false_start = (r_state == ST_PENALTY);
    assign done        = (r_state == ST_DONE);
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed self-checking bench for reaction_round_ctrl with default parameters.
module tb_reaction_round_ctrl;

    localparam logic [31:0] S_IDLE    = 32'd0;
    localparam logic [31:0] S_ARM     = 32'd1;
    localparam logic [31:0] S_LIGHTS  = 32'd2;
    localparam logic [31:0] S_MEASURE = 32'd3;
    localparam logic [31:0] S_RECORD  = 32'd4;
    localparam logic [31:0] S_PENALTY = 32'd5;
    localparam logic [31:0] S_DONE    = 32'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        start_btn;
    logic        react_btn;
    logic        lights_out;
    logic        trigger;
    logic        seq_abort;
    logic [13:0] rt_ms;
    logic [13:0] best_ms;
    logic [2:0]  round_idx;
    logic        false_start;
    logic        done;
    logic [2:0]  state_dbg;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    reaction_round_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .start_btn   (start_btn),
        .react_btn   (react_btn),
        .lights_out  (lights_out),
        .trigger     (trigger),
        .seq_abort   (seq_abort),
        .rt_ms       (rt_ms),
        .best_ms     (best_ms),
        .round_idx   (round_idx),
        .false_start (false_start),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the edge.
    task automatic applyStimulus(input logic st, input logic rc, input logic lo, input logic tk);
        start_btn  = st;
        react_btn  = rc;
        lights_out = lo;
        tick       = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tickCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, 32'(state_dbg), S_IDLE);
        checkOutput({tag, "_rt"}, 32'(rt_ms), 32'd0);
        checkOutput({tag, "_best"}, 32'(best_ms), 32'd9999);
        checkOutput({tag, "_round"}, 32'(round_idx), 32'd0);
        checkOutput({tag, "_trig"}, 32'(trigger), 32'd0);
        checkOutput({tag, "_abort"}, 32'(seq_abort), 32'd0);
        checkOutput({tag, "_fs"}, 32'(false_start), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Plays one round starting in ARM: lights_out, n ticks, react press.
    task automatic runRound(input int n, input int expRound, input int expBest);
        checkOutput("rr_arm_state", 32'(state_dbg), S_ARM);
        checkOutput("rr_arm_trig", 32'(trigger), 32'd1);
        idleCycles(1);
        checkOutput("rr_lights_state", 32'(state_dbg), S_LIGHTS);
        checkOutput("rr_lights_trig", 32'(trigger), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rr_measure_state", 32'(state_dbg), S_MEASURE);
        tickCycles(n);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rr_record_state", 32'(state_dbg), S_RECORD);
        idleCycles(1);
        checkOutput("rr_rt", 32'(rt_ms), 32'(n));
        checkOutput("rr_best", 32'(best_ms), 32'(expBest));
        checkOutput("rr_round", 32'(round_idx), 32'(expRound));
    endtask

    initial begin
        rst_n      = 1'b0;
        tick       = 1'b0;
        start_btn  = 1'b0;
        react_btn  = 1'b0;
        lights_out = 1'b0;

        idleCycles(2);
        checkResetValues("reset");

        // Start held through reset release must not begin a session.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("held_start_state", 32'(state_dbg), S_IDLE);
        idleCycles(1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runRound(250, 1, 250);
        checkOutput("normal_state", 32'(state_dbg), S_ARM);

        rst_n = 1'b0;
        idleCycles(1);
        rst_n = 1'b1;
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sess_round0", 32'(round_idx), 32'd0);
        runRound(300, 1, 300);
        runRound(180, 2, 180);
        runRound(220, 3, 180);
        runRound(400, 4, 180);
        runRound(190, 5, 180);
        checkOutput("sess_done", 32'(done), 32'd1);
        checkOutput("sess_state", 32'(state_dbg), S_DONE);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        idleCycles(2);
        checkOutput("done_hold_state", 32'(state_dbg), S_DONE);
        checkOutput("done_hold_rt", 32'(rt_ms), 32'd190);
        checkOutput("done_hold_best", 32'(best_ms), 32'd180);
        checkOutput("done_hold_round", 32'(round_idx), 32'd5);
        checkOutput("done_hold_trig", 32'(trigger), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_state", 32'(state_dbg), S_ARM);
        checkOutput("restart_trig", 32'(trigger), 32'd1);
        checkOutput("restart_round", 32'(round_idx), 32'd0);
        checkOutput("restart_rt", 32'(rt_ms), 32'd0);
        checkOutput("restart_best", 32'(best_ms), 32'd9999);
        checkOutput("restart_done", 32'(done), 32'd0);

        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("fs_state", 32'(state_dbg), S_PENALTY);
        checkOutput("fs_abort", 32'(seq_abort), 32'd1);
        checkOutput("fs_flag", 32'(false_start), 32'd1);
        idleCycles(1);
        checkOutput("fs_abort_off", 32'(seq_abort), 32'd0);
        tickCycles(500);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(1);
        tickCycles(499);
        checkOutput("fs_999_state", 32'(state_dbg), S_PENALTY);
        checkOutput("fs_999_flag", 32'(false_start), 32'd1);
        tickCycles(1);
        checkOutput("fs_exit_state", 32'(state_dbg), S_ARM);
        checkOutput("fs_exit_trig", 32'(trigger), 32'd1);
        checkOutput("fs_exit_flag", 32'(false_start), 32'd0);
        checkOutput("fs_exit_round", 32'(round_idx), 32'd0);
        checkOutput("fs_exit_rt", 32'(rt_ms), 32'd0);

        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("simul_state", 32'(state_dbg), S_PENALTY);
        checkOutput("simul_abort", 32'(seq_abort), 32'd1);
        tickCycles(1000);
        checkOutput("simul_exit_state", 32'(state_dbg), S_ARM);
        checkOutput("simul_exit_trig", 32'(trigger), 32'd1);

        // Stray start/lights_out in MEASURE must not restart or clear timing.
        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tickCycles(60);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("stray_state", 32'(state_dbg), S_MEASURE);
        tickCycles(60);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("tickreact_state", 32'(state_dbg), S_RECORD);
        idleCycles(1);
        checkOutput("tickreact_rt", 32'(rt_ms), 32'd120);
        checkOutput("tickreact_best", 32'(best_ms), 32'd120);
        checkOutput("tickreact_round", 32'(round_idx), 32'd1);

        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tickCycles(9998);
        checkOutput("to_9998_state", 32'(state_dbg), S_MEASURE);
        tickCycles(1);
        checkOutput("to_record_state", 32'(state_dbg), S_RECORD);
        idleCycles(1);
        checkOutput("to_rt", 32'(rt_ms), 32'd9999);
        checkOutput("to_best", 32'(best_ms), 32'd120);
        checkOutput("to_round", 32'(round_idx), 32'd2);
        checkOutput("to_state", 32'(state_dbg), S_ARM);

        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tickCycles(50);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkResetValues("midreset");
        rst_n = 1'b1;
        idleCycles(1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
